// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;
  localparam int REG_W    = 5;
  localparam int NREG_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } mc_state_t;
endpackage

// File: rtl/mc_scoreboard.sv
// Multi-cycle unit tracker: issue/latency FSM, pending-destination scoreboard
// and the registered writeback strobe.
module mc_scoreboard
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 4,
  parameter int NREG   = NREG_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mc_start_E,
  input  logic [REG_W-1:0] rd_E,
  output logic [1:0]       state,
  output logic [NREG-1:0]  pending,
  output logic             mc_wb,
  output logic [REG_W-1:0] mc_wb_rd
);
  localparam int CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

  mc_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [REG_W-1:0] r_wb_rd;
  logic [NREG-1:0]  r_pending;
  logic             r_mc_wb;
  logic [REG_W-1:0] r_mc_wb_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_wb_rd    <= '0;
      r_pending  <= '0;
      r_mc_wb    <= 1'b0;
      r_mc_wb_rd <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mc_start_E) begin
            r_state <= BUSY;
            r_cnt   <= CNT_W'(MC_LAT - 2);
            r_wb_rd <= rd_E;
            // x0 is never tracked, so the loop starts at 1
            for (int r = 1; r < NREG; r++) begin
              if (rd_E == REG_W'(r)) r_pending[r] <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_state    <= WB;
            r_mc_wb    <= 1'b1;
            r_mc_wb_rd <= r_wb_rd;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        WB: begin
          r_state    <= IDLE;
          r_mc_wb    <= 1'b0;
          r_mc_wb_rd <= '0;
          for (int r = 0; r < NREG; r++) begin
            if (r_wb_rd == REG_W'(r)) r_pending[r] <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign state    = r_state;
  assign pending  = r_pending;
  assign mc_wb    = r_mc_wb;
  assign mc_wb_rd = r_mc_wb_rd;
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller: load-use, scoreboard (RAW/WAW on multi-cycle results),
// multi-cycle structural hazard, and taken-branch flush.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 4,
  parameter int NREG   = NREG_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs1_D,
  input  logic [REG_W-1:0] rs2_D,
  input  logic [REG_W-1:0] rd_D,
  input  logic             reg_wr_D,
  input  logic             mc_op_D,
  input  logic [REG_W-1:0] rd_E,
  input  logic             load_E,
  input  logic             mc_start_E,
  input  logic             pc_src_E,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_D,
  output logic             flush_E,
  output logic             mc_busy,
  output logic             mc_wb,
  output logic [REG_W-1:0] mc_wb_rd,
  output logic [NREG-1:0]  pending
);
  logic [1:0]      w_state;
  logic [NREG-1:0] w_start_hot;
  logic [NREG-1:0] w_pend_now;
  logic [NREG-1:0] w_sb_hit;
  logic            w_lw_hz;
  logic            w_sb_hz;
  logic            w_st_hz;
  logic            w_hz;

  mc_scoreboard #(
    .MC_LAT(MC_LAT),
    .NREG  (NREG)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .mc_start_E(mc_start_E),
    .rd_E      (rd_E),
    .state     (w_state),
    .pending   (pending),
    .mc_wb     (mc_wb),
    .mc_wb_rd  (mc_wb_rd)
  );

  // The issuing op's destination counts as pending in its own issue cycle
  for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
    assign w_start_hot[gi] = mc_start_E && (gi != 0) && (rd_E == REG_W'(gi));
    assign w_pend_now[gi]  = pending[gi] | w_start_hot[gi];
    assign w_sb_hit[gi]    = w_pend_now[gi] &
                             ((rs1_D == REG_W'(gi)) | (rs2_D == REG_W'(gi)) |
                              (reg_wr_D & (rd_D == REG_W'(gi))));
  end

  assign w_lw_hz = load_E & (rd_E != '0) & ((rd_E == rs1_D) | (rd_E == rs2_D));
  assign w_sb_hz = |w_sb_hit;
  assign w_st_hz = mc_op_D & ((mc_state_t'(w_state) == BUSY) | mc_start_E);
  assign w_hz    = w_lw_hz | w_sb_hz | w_st_hz;

  // A taken branch makes the D instruction wrong-path, so it wins over any stall
  assign stall_F = w_hz & ~pc_src_E;
  assign stall_D = w_hz & ~pc_src_E;
  assign flush_E = w_hz | pc_src_E;
  assign flush_D = pc_src_E;
  assign mc_busy = (mc_state_t'(w_state) != IDLE);
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Stall/flush controller for the 5-stage pipeline. It complements the execute-stage forwarding unit by handling the hazards forwarding cannot resolve: load-use, taken-branch flushes, and results produced by the multi-cycle (mul/div) unit. It tracks in-flight multi-cycle destinations in a scoreboard and drives F/D stall and D/E flush controls. It also issues the multi-cycle writeback strobe.

## Interface
- `MC_LAT`, default 4: cycles from multi-cycle issue in E to its writeback strobe; legal range ≥ 2.
- `NREG`, default 32: architectural register count.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rs1_D`, `rs2_D` in 5 each: source registers of the instruction in D.
- `rd_D` in 5: destination register of the instruction in D.
- `reg_wr_D` in 1: the D instruction writes `rd_D`.
- `mc_op_D` in 1: the D instruction is a multi-cycle op.
- `rd_E` in 5: destination register of the instruction in E.
- `load_E` in 1: the E instruction is a load.
- `mc_start_E` in 1: the E instruction is a multi-cycle op issuing this cycle.
- `pc_src_E` in 1: taken branch/jump resolved in E.
- `stall_F`, `stall_D` out 1: hold the PC and IF/ID registers.
- `flush_D`, `flush_E` out 1: clear the IF/ID and ID/EX registers on the next edge.
- `mc_busy` out 1: FSM is not IDLE.
- `mc_wb` out 1: one-cycle multi-cycle writeback strobe.
- `mc_wb_rd` out 5: destination register for `mc_wb`.
- `pending` out NREG: scoreboard; bit r is set while register r awaits a multi-cycle result.

## Operation
- **Register x0:** never hazards, never set in the scoreboard. Every register compare is qualified by "register ≠ 0".
- **Load-use:**
  - `lw_hz` = `load_E` & (`rd_E` == `rs1_D` | `rd_E` == `rs2_D`).
- **Scoreboard:**
  - `pend_now` = `pending`, OR'd with the one-hot of `rd_E` when `mc_start_E`.
  - `sb_hz` = `pend_now`[`rs1_D`] | `pend_now`[`rs2_D`] | (`reg_wr_D` & `pend_now`[`rd_D`]). The last term covers WAW.
- **Structural:**
  - `st_hz` = `mc_op_D` & (state == BUSY | `mc_start_E`).
- **`hz`** = `lw_hz` | `sb_hz` | `st_hz`.
- **Outputs, combinational:**
  - `stall_F` = `stall_D` = `hz` & !`pc_src_E`.
  - `flush_E` = `hz` | `pc_src_E`.
  - `flush_D` = `pc_src_E`.
  - A taken branch overrides every stall, because the D instruction is wrong-path.
- **FSM (`mc_state_t`): IDLE, BUSY, WB.**
  - IDLE → BUSY on `mc_start_E`. Load `cnt` = MC_LAT−2, latch `wb_rd` = `rd_E`, and set `pending`[`rd_E`] if `rd_E` ≠ 0.
  - BUSY: decrement `cnt`; go to WB when `cnt` == 0.
  - WB: `mc_wb` = 1, `mc_wb_rd` = `wb_rd`. Clear `pending`[`wb_rd`] at the closing edge, then go to IDLE.
  - `mc_start_E` outside IDLE is illegal; `st_hz` guarantees it cannot occur. It is ignored, and the bench asserts it never happens.
- **`cnt` width:** $clog2(MC_LAT). `cnt` never underflows.

## Timing
- **Reset:** `rst_n` low asynchronously forces state IDLE, `pending` = 0, `cnt` = 0, `wb_rd` = 0.
  - All outputs read 0 while reset is asserted, except the combinational stall/flush terms driven by inputs. With `pending` = 0, only `lw_hz`, `st_hz` via `mc_start_E`, and `pc_src_E` can assert them.
  - Reset mid-BUSY or mid-WB abandons the op; no `mc_wb` is issued.
- **Issue timeline:** with `mc_start_E` at cycle t:
  - BUSY during t+1 … t+MC_LAT−1.
  - WB (`mc_wb` = 1) at cycle t+MC_LAT.
  - `pending` bit high during t+1 … t+MC_LAT; low at t+MC_LAT+1.
- **Consumer stall:** a D consumer of that register stalls from cycle t through t+MC_LAT. It proceeds at t+MC_LAT+1.
- **Back-to-back multi-cycle ops:** a `mc_op_D` stalls while state is BUSY, and in cycle t itself. It is released in the WB cycle and enters E when the FSM is IDLE.
- **Load-use stall:** exactly one cycle, since the load then leaves E.
- **Simultaneous events:**
  - `pc_src_E` together with any hazard: flush both D and E, no stall.
  - `mc_start_E` together with `pc_src_E` cannot coincide (single E instruction). No special handling.

## Structure
- **`hazard_pkg`:** `mc_state_t` enum, `REG_W` = 5, `NREG_DEF` = 32.
- **Sub-module `mc_scoreboard`:** contains the FSM, `cnt`, `wb_rd` and `pending`. It exports `pending`, `state`, `mc_wb` and `mc_wb_rd`.
- **`hazard_ctrl`:** instantiates `mc_scoreboard` and holds the combinational hazard/stall/flush logic.

## Test plan
- **Load-use:** `load_E` = 1, `rd_E` = 5, `rs1_D` = 5 → `stall_F` = `stall_D` = `flush_E` = 1 and `flush_D` = 0 for exactly one cycle. With `rd_E` = `rs1_D` = 0 → no stall.
- **Branch priority:** `pc_src_E` = 1 with load-use on `rs2_D` = 9 → `flush_D` = `flush_E` = 1, `stall_F` = `stall_D` = 0.
- **Multi-cycle timeline:** MC_LAT = 4, `mc_start_E` with `rd_E` = 7 at cycle 0 → `pending`[7] = 1 in cycles 1–4. `mc_busy` = 1 in cycles 1–4. `mc_wb` = 1 with `mc_wb_rd` = 7 at cycle 4 only. With `rs2_D` = 7 held, the stall is high in cycles 0–4 and low at cycle 5.
- **WAW:** `reg_wr_D` = 1 with `rd_D` = 7 while `pending`[7] → stall. Source or destination register 8 → no stall.
- **Structural:** `mc_op_D` = 1 at cycle 0 (the `mc_start_E` cycle) and during BUSY → stall. During the WB cycle → no stall; the next `mc_start_E` is accepted in IDLE.
- **Reset mid-op:** `rst_n` pulled low at cycle 2 of a MC_LAT = 4 op → `pending` = 0 and `mc_busy` = 0 immediately. No `mc_wb` at cycle 4. A new `mc_start_E` after release behaves as in the multi-cycle timeline test.
